// File: rtl/myproject_mul_pipe_sat.sv
// Pipelined signed multiplier with round-half-up shift and narrowing.
// Optional clamp-and-flag on overflow under MYPROJECT_MUL_SAT_EN.
module myproject_mul_pipe_sat #(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 10,
  parameter int DOUT_WIDTH = 22,
  parameter int NUM_STAGE  = 4,
  parameter int SHIFT      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int W = DIN0_WIDTH + DIN1_WIDTH;

  logic [NUM_STAGE:1]    vld;
  logic [DIN0_WIDTH-1:0] a_q;
  logic [DIN1_WIDTH-1:0] b_q;
  logic [W-1:0]          prod_q;
  logic [W:0]            shifted;
  logic [DOUT_WIDTH-1:0] narrow;
  logic [DOUT_WIDTH-1:0] data_q [3:NUM_STAGE];

  // One extra bit keeps the +half from overflowing the product
  generate
    if (SHIFT > 0) begin : g_rnd
      localparam logic [W:0] HALF = (W+1)'(1) << (SHIFT-1);
      logic [W:0] rnd;
      assign rnd     = {prod_q[W-1], prod_q} + HALF;
      assign shifted = $signed(rnd) >>> SHIFT;
    end else begin : g_nornd
      assign shifted = {prod_q[W-1], prod_q};
    end
  endgenerate

`ifdef MYPROJECT_MUL_SAT_EN
  logic [W-DOUT_WIDTH+1:0] hi;
  logic                    fits;
  logic                    ovf_n;
  logic                    ovf_q [3:NUM_STAGE];

  assign hi = shifted[W:DOUT_WIDTH-1];

  always_comb begin
    fits  = (&hi) | ~(|hi);
    ovf_n = ~fits;
    if (fits)
      narrow = shifted[DOUT_WIDTH-1:0];
    else if (shifted[W])
      narrow = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
    else
      narrow = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  end

  assign ovf = ovf_q[NUM_STAGE];
`else
  logic unused_hi;

  assign narrow    = shifted[DOUT_WIDTH-1:0];
  assign unused_hi = ^shifted[W:DOUT_WIDTH];
  assign ovf       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      vld    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
      for (int s = 3; s <= NUM_STAGE; s++) begin
        data_q[s] <= '0;
`ifdef MYPROJECT_MUL_SAT_EN
        ovf_q[s]  <= 1'b0;
`endif
      end
    end else if (ce) begin
      vld <= {vld[NUM_STAGE-1:1], in_valid};
      if (in_valid) begin
        a_q <= din0;
        b_q <= din1;
      end
      if (vld[1])
        prod_q <= W'($signed(a_q)) * W'($signed(b_q));
      if (vld[2]) begin
        data_q[3] <= narrow;
`ifdef MYPROJECT_MUL_SAT_EN
        ovf_q[3]  <= ovf_n;
`endif
      end
      for (int s = 4; s <= NUM_STAGE; s++) begin
        if (vld[s-1]) begin
          data_q[s] <= data_q[s-1];
`ifdef MYPROJECT_MUL_SAT_EN
          ovf_q[s]  <= ovf_q[s-1];
`endif
        end
      end
    end
  end

  assign out_valid = vld[NUM_STAGE];
  assign dout      = data_q[NUM_STAGE];

endmodule

// File: tb/tb_myproject_mul_pipe_sat.sv
// Directed bench for myproject_mul_pipe_sat: default lane plus a SHIFT=4 lane.
// Expected values follow MYPROJECT_MUL_SAT_EN when it is defined.
module tb_myproject_mul_pipe_sat;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        ce = 1'b1;
  logic        iv_a = 1'b0;
  logic        iv_b = 1'b0;
  logic [15:0] a0 = '0;
  logic [9:0]  a1 = '0;
  logic [15:0] b0 = '0;
  logic [9:0]  b1 = '0;
  logic        ov_a, ov_b, of_a, of_b;
  logic [21:0] do_a, do_b;

  myproject_mul_pipe_sat dut_a (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(iv_a),
    .din0(a0), .din1(a1),
    .out_valid(ov_a), .dout(do_a), .ovf(of_a)
  );

  myproject_mul_pipe_sat #(.SHIFT(4)) dut_b (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(iv_b),
    .din0(b0), .din1(b1),
    .out_valid(ov_b), .dout(do_b), .ovf(of_b)
  );

  typedef struct {
    int y;
    bit o;
  } exp_t;

  typedef struct {
    logic signed [15:0] a;
    logic signed [9:0]  b;
    int                 y;
    bit                 o;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t last_a = '{0, 1'b0};
  exp_t last_b = '{0, 1'b0};
  vec_t vtab[10];
  vec_t stab[5];
  logic ovr[12];

  function automatic void chk(string n, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", n, got, exp);
    end
  endfunction

  function automatic vec_t mk(int a, int b, int yw, int ys, bit os);
    vec_t v;
    v.a = 16'(a);
    v.b = 10'(b);
`ifdef MYPROJECT_MUL_SAT_EN
    v.y = ys;
    v.o = os;
`else
    v.y = yw;
    v.o = 1'b0;
    if (os) v.o = 1'b0;
`endif
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (qa.size() + qb.size()) != 0; i++)
      tick();
    chk("drain", qa.size() + qb.size(), 0);
  endtask

  // Scoreboard: a new result exists only after an enabled edge
  logic rst_s = 1'b0;
  logic ce_s = 1'b0;
  always @(posedge clk) begin
    rst_s <= reset;
    ce_s  <= ce;
  end

  always @(negedge clk) begin
    if (rst_s) begin
      chk("rst_valid_a", int'(ov_a), 0);
      chk("rst_dout_a", int'($signed(do_a)), 0);
      chk("rst_ovf_a", int'(of_a), 0);
      chk("rst_valid_b", int'(ov_b), 0);
      chk("rst_dout_b", int'($signed(do_b)), 0);
      qa.delete();
      qb.delete();
      last_a = '{0, 1'b0};
      last_b = '{0, 1'b0};
    end else begin
      if (ov_a && ce_s) begin
        if (qa.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_a: got dout %0d, expected no result",
                   $signed(do_a));
        end else begin
          last_a = qa.pop_front();
          chk("dout_a", int'($signed(do_a)), last_a.y);
          chk("ovf_a", int'(of_a), int'(last_a.o));
        end
      end else if (!ov_a) begin
        chk("hold_dout_a", int'($signed(do_a)), last_a.y);
        chk("hold_ovf_a", int'(of_a), int'(last_a.o));
      end
      if (ov_b && ce_s) begin
        if (qb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_b: got dout %0d, expected no result",
                   $signed(do_b));
        end else begin
          last_b = qb.pop_front();
          chk("dout_b", int'($signed(do_b)), last_b.y);
          chk("ovf_b", int'(of_b), int'(last_b.o));
        end
      end else if (!ov_b) begin
        chk("hold_dout_b", int'($signed(do_b)), last_b.y);
      end
    end
  end

  initial begin
    int n;

    vtab[0] = mk(100, -3, -300, -300, 1'b0);
    vtab[1] = mk(-32768, -512, 0, 2097151, 1'b1);
    vtab[2] = mk(32767, 511, -33279, 2097151, 1'b1);
    vtab[3] = mk(-32768, 511, 32768, -2097152, 1'b1);
    vtab[4] = mk(1234, -56, -69104, -69104, 1'b0);
    vtab[5] = mk(4096, 511, 2093056, 2093056, 1'b0);
    vtab[6] = mk(4096, -512, -2097152, -2097152, 1'b0);
    vtab[7] = mk(-4096, -512, -2097152, 2097151, 1'b1);
    vtab[8] = mk(0, -512, 0, 0, 1'b0);
    vtab[9] = mk(-1, -1, 1, 1, 1'b0);

    stab[0] = mk(7, 5, 2, 2, 1'b0);
    stab[1] = mk(-7, 5, -2, -2, 1'b0);
    stab[2] = mk(8, 1, 1, 1, 1'b0);
    stab[3] = mk(-8, 1, 0, 0, 1'b0);
    stab[4] = mk(32767, 511, 1046496, 1046496, 1'b0);

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Single sample: exact four-cycle latency
    a0 = 16'(100);
    a1 = 10'(-3);
    iv_a = 1'b1;
    qa.push_back('{-300, 1'b0});
    tick();
    iv_a = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("lat_idle", int'(ov_a), 0);
      tick();
    end
    @(negedge clk);
    chk("lat_valid", int'(ov_a), 1);
    tick();
    drain();

    // Back-to-back table, wrap/saturation boundaries
    for (int i = 0; i < 10; i++) begin
      a0 = vtab[i].a;
      a1 = vtab[i].b;
      iv_a = 1'b1;
      qa.push_back('{vtab[i].y, vtab[i].o});
      tick();
    end
    iv_a = 1'b0;
    drain();

    // Rounding lane
    for (int i = 0; i < 5; i++) begin
      b0 = stab[i].a;
      b1 = stab[i].b;
      iv_b = 1'b1;
      qb.push_back('{stab[i].y, stab[i].o});
      tick();
    end
    iv_b = 1'b0;
    drain();

    // Ten-sample stream with ce low on cycles 3 and 6
    n = 0;
    for (int c = 0; n < 10 && c < 40; c++) begin
      ce = !(c == 3 || c == 6);
      a0 = 16'(n * 37 - 150);
      a1 = 10'(n - 4);
      iv_a = 1'b1;
      if (ce) begin
        qa.push_back('{(n * 37 - 150) * (n - 4), 1'b0});
        n++;
      end
      tick();
    end
    ce = 1'b1;
    iv_a = 1'b0;
    chk("ce_sent", n, 10);
    drain();

    // Alternating valid / bubble
    for (int c = 0; c < 12; c++) begin
      if (c < 6) begin
        iv_a = (c % 2 == 0);
        a0 = 16'(c * 1000 + 1);
        a1 = 10'(-7);
        if (iv_a) qa.push_back('{(c * 1000 + 1) * -7, 1'b0});
      end else begin
        iv_a = 1'b0;
      end
      @(negedge clk);
      ovr[c] = ov_a;
      tick();
    end
    for (int c = 4; c < 10; c++)
      chk("alt_valid", int'(ovr[c]), (c % 2 == 0) ? 1 : 0);
    drain();

    // Reset with three samples in flight, ce low on the reset cycle
    for (int c = 0; c < 3; c++) begin
      a0 = 16'(c + 500);
      a1 = 10'(9);
      iv_a = 1'b1;
      if (c == 2) begin
        reset = 1'b1;
        ce = 1'b0;
      end else begin
        qa.push_back('{(c + 500) * 9, 1'b0});
      end
      tick();
    end
    reset = 1'b0;
    ce = 1'b1;
    iv_a = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("post_rst_valid", int'(ov_a), 0);
      tick();
    end
    chk("post_rst_queue", qa.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
